// File: rtl/reg_table_pkg.sv
// reg_table_pkg: shared widths, FSM state type and writeback payload for the
// quad-word register table, its read forwarding logic and the issue/pipe stages.
package reg_table_pkg;

  localparam int unsigned REG_ADDR_W = 7;
  localparam int unsigned REG_DEPTH  = 128;
  localparam int unsigned QUAD_W     = 128;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rt_state_t;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [QUAD_W-1:0]     quad_t;

  // One writeback port: enable, destination register, data.
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    quad_t     data;
  } wb_t;

  // True when an enabled writeback targets the given read address.
  function automatic logic wb_hit(input wb_t wb, input reg_addr_t addr);
    return wb.en && (wb.addr == addr);
  endfunction

endpackage

// File: rtl/reg_table_if.sv
// reg_table_if: read and writeback bus of the register table.
//   master (issue/pipes): drives rd_en, the three source addresses, and both
//                         writeback ports; receives read data, rd_valid,
//                         ready and wr_conflict.
//   slave  (reg_table)  : the mirror image.
interface reg_table_if;
  import reg_table_pkg::*;

  logic      rd_en;
  reg_addr_t ra_addr;
  reg_addr_t rb_addr;
  reg_addr_t rc_addr;
  quad_t     ra;
  quad_t     rb;
  quad_t     rt_st;
  logic      rd_valid;

  logic      reg_write_wb_e;
  reg_addr_t rt_addr_wb_e;
  quad_t     rt_wb_e;

  logic      reg_write_wb;
  reg_addr_t rt_addr_wb;
  quad_t     rt_wb;

  logic      ready;
  logic      wr_conflict;

  modport master (
    output rd_en, ra_addr, rb_addr, rc_addr,
    output reg_write_wb_e, rt_addr_wb_e, rt_wb_e,
    output reg_write_wb, rt_addr_wb, rt_wb,
    input  ra, rb, rt_st, rd_valid, ready, wr_conflict
  );

  modport slave (
    input  rd_en, ra_addr, rb_addr, rc_addr,
    input  reg_write_wb_e, rt_addr_wb_e, rt_wb_e,
    input  reg_write_wb, rt_addr_wb, rt_wb,
    output ra, rb, rt_st, rd_valid, ready, wr_conflict
  );

endinterface

// File: rtl/reg_table_fwd.sv
// reg_table_fwd: write-before-read forwarding mux for one read port.
//   addr    : read address of this port
//   wb_odd  : odd-pipe writeback (highest priority)
//   wb_even : even-pipe writeback
//   stored  : table content at addr
//   data_c  : combinational forwarded read data
module reg_table_fwd
  import reg_table_pkg::*;
(
  input  reg_addr_t addr,
  input  wb_t       wb_odd,
  input  wb_t       wb_even,
  input  quad_t     stored,
  output quad_t     data_c
);

  // Odd pipe overrides even pipe, which overrides the array.
  always_comb begin
    data_c = stored;
    if (wb_hit(wb_even, addr)) data_c = wb_even.data;
    if (wb_hit(wb_odd, addr))  data_c = wb_odd.data;
  end

endmodule

// File: rtl/reg_table.sv
// reg_table: 128 x 128-bit register table with three read ports and two
// writeback ports (even and odd pipe).
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-low reset
//   bus   : reg_table_if.slave -- reads (1-cycle latency, registered data,
//           rd_valid), two writebacks with same-cycle bypass, ready,
//           wr_conflict
// After reset the table sweeps zeros into every entry (INIT) before
// accepting traffic (READY).
module reg_table #(
  parameter int unsigned REG_DEPTH = 128,
  parameter int unsigned QUAD_W    = 128
) (
  input logic        clk,
  input logic        reset,
  reg_table_if.slave bus
);
  import reg_table_pkg::*;

  rt_state_t         state;
  reg_addr_t         sweep;
  logic [QUAD_W-1:0] mem [REG_DEPTH];

  logic  ready_q;
  logic  rd_valid_q;
  logic  wr_conflict_q;
  quad_t ra_q;
  quad_t rb_q;
  quad_t rt_st_q;

  wb_t   wb_odd;
  wb_t   wb_even;
  quad_t ra_c;
  quad_t rb_c;
  quad_t rt_st_c;

  assign wb_odd  = '{en: bus.reg_write_wb,   addr: bus.rt_addr_wb,   data: bus.rt_wb};
  assign wb_even = '{en: bus.reg_write_wb_e, addr: bus.rt_addr_wb_e, data: bus.rt_wb_e};

  // Forwarding muxes, one per read port.
  reg_table_fwd u_fwd_ra (
    .addr    (bus.ra_addr),
    .wb_odd  (wb_odd),
    .wb_even (wb_even),
    .stored  (mem[bus.ra_addr]),
    .data_c  (ra_c)
  );

  reg_table_fwd u_fwd_rb (
    .addr    (bus.rb_addr),
    .wb_odd  (wb_odd),
    .wb_even (wb_even),
    .stored  (mem[bus.rb_addr]),
    .data_c  (rb_c)
  );

  reg_table_fwd u_fwd_rc (
    .addr    (bus.rc_addr),
    .wb_odd  (wb_odd),
    .wb_even (wb_even),
    .stored  (mem[bus.rc_addr]),
    .data_c  (rt_st_c)
  );

  // FSM, sweep counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= INIT;
      sweep         <= '0;
      ready_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      wr_conflict_q <= 1'b0;
      ra_q          <= '0;
      rb_q          <= '0;
      rt_st_q       <= '0;
    end else begin
      rd_valid_q    <= 1'b0;
      wr_conflict_q <= 1'b0;
      case (state)
        INIT: begin
          sweep <= REG_ADDR_W'(sweep + 1'b1);
          if (sweep == REG_ADDR_W'(REG_DEPTH - 1)) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (bus.rd_en) begin
            ra_q       <= ra_c;
            rb_q       <= rb_c;
            rt_st_q    <= rt_st_c;
            rd_valid_q <= 1'b1;
          end
          wr_conflict_q <= wb_even.en && wb_odd.en && (wb_even.addr == wb_odd.addr);
        end
        default: begin
          state   <= INIT;
          sweep   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage: zero sweep in INIT, pipe writebacks in READY; odd written last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == INIT) begin
        mem[sweep] <= '0;
      end else begin
        if (wb_even.en) mem[wb_even.addr] <= wb_even.data;
        if (wb_odd.en)  mem[wb_odd.addr]  <= wb_odd.data;
      end
    end
  end

  assign bus.ready       = ready_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.ra          = ra_q;
  assign bus.rb          = rb_q;
  assign bus.rt_st       = rt_st_q;

endmodule
